// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use stall, redirect flush, EX forwarding selects
// and saturating stall/flush event counters.
module id_ex_hazard_stage #(
    parameter int XLEN  = 32,
    parameter int RA_W  = 5,
    parameter int ALU_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [RA_W-1:0]  rs1_d,
    input  logic [RA_W-1:0]  rs2_d,
    input  logic [RA_W-1:0]  rd_d,
    input  logic [XLEN-1:0]  rd1_d,
    input  logic [XLEN-1:0]  rd2_d,
    input  logic [XLEN-1:0]  imm_d,
    input  logic [XLEN-1:0]  pc_d,
    input  logic             reg_write_d,
    input  logic             mem_read_d,
    input  logic             mem_write_d,
    input  logic             alu_src_d,
    input  logic             branch_d,
    input  logic             jump_d,
    input  logic [ALU_W-1:0] alu_ctrl_d,
    input  logic             pc_src_e,
    input  logic [RA_W-1:0]  rd_m,
    input  logic [RA_W-1:0]  rd_w,
    input  logic             reg_write_m,
    input  logic             reg_write_w,
    output logic [RA_W-1:0]  rs1_e,
    output logic [RA_W-1:0]  rs2_e,
    output logic [RA_W-1:0]  rd_e,
    output logic [XLEN-1:0]  rd1_e,
    output logic [XLEN-1:0]  rd2_e,
    output logic [XLEN-1:0]  imm_e,
    output logic [XLEN-1:0]  pc_e,
    output logic             reg_write_e,
    output logic             mem_read_e,
    output logic             mem_write_e,
    output logic             alu_src_e,
    output logic             branch_e,
    output logic             jump_e,
    output logic [ALU_W-1:0] alu_ctrl_e,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_d,
    output logic [1:0]       forward_a_e,
    output logic [1:0]       forward_b_e,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef struct packed {
        logic [RA_W-1:0]  rs1;
        logic [RA_W-1:0]  rs2;
        logic [RA_W-1:0]  rd;
        logic [XLEN-1:0]  rd1;
        logic [XLEN-1:0]  rd2;
        logic [XLEN-1:0]  imm;
        logic [XLEN-1:0]  pc;
        logic             reg_write;
        logic             mem_read;
        logic             mem_write;
        logic             alu_src;
        logic             branch;
        logic             jump;
        logic [ALU_W-1:0] alu_ctrl;
    } ex_regs_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    ex_regs_t         ex_q, ex_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic       load_use;
    logic       stall;
    logic       bubble_e;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;

    // x0 is hardwired, so it can never be the source of a hazard or a forward.
    function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] rs);
        logic [1:0] sel;
        sel = FWD_REG;
        if (reg_write_m && (rd_m != '0) && (rd_m == rs)) begin
            sel = FWD_MEM;
        end else if (reg_write_w && (rd_w != '0) && (rd_w == rs)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

    always_comb begin
        load_use = ex_q.mem_read && (ex_q.rd != '0) &&
                   ((ex_q.rd == rs1_d) || (ex_q.rd == rs2_d));
        // A redirect discards the decode instruction, so stalling it would be pointless.
        stall    = load_use && !pc_src_e;
        bubble_e = load_use || pc_src_e;
        fwd_a    = fwd_sel(ex_q.rs1);
        fwd_b    = fwd_sel(ex_q.rs2);
    end

    always_comb begin
        stall_f     = 1'b0;
        stall_d     = 1'b0;
        flush_d     = 1'b0;
        forward_a_e = FWD_REG;
        forward_b_e = FWD_REG;
        if (!reset) begin
            stall_f     = stall;
            stall_d     = stall;
            flush_d     = pc_src_e;
            forward_a_e = fwd_a;
            forward_b_e = fwd_b;
        end
    end

    always_comb begin
        ex_d = '0;
        if (!bubble_e) begin
            ex_d.rs1       = rs1_d;
            ex_d.rs2       = rs2_d;
            ex_d.rd        = rd_d;
            ex_d.rd1       = rd1_d;
            ex_d.rd2       = rd2_d;
            ex_d.imm       = imm_d;
            ex_d.pc        = pc_d;
            ex_d.reg_write = reg_write_d;
            ex_d.mem_read  = mem_read_d;
            ex_d.mem_write = mem_write_d;
            ex_d.alu_src   = alu_src_d;
            ex_d.branch    = branch_d;
            ex_d.jump      = jump_d;
            ex_d.alu_ctrl  = alu_ctrl_d;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (pc_src_e && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign rs1_e       = ex_q.rs1;
    assign rs2_e       = ex_q.rs2;
    assign rd_e        = ex_q.rd;
    assign rd1_e       = ex_q.rd1;
    assign rd2_e       = ex_q.rd2;
    assign imm_e       = ex_q.imm;
    assign pc_e        = ex_q.pc;
    assign reg_write_e = ex_q.reg_write;
    assign mem_read_e  = ex_q.mem_read;
    assign mem_write_e = ex_q.mem_write;
    assign alu_src_e   = ex_q.alu_src;
    assign branch_e    = ex_q.branch;
    assign jump_e      = ex_q.jump;
    assign alu_ctrl_e  = ex_q.alu_ctrl;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Directed bench for id_ex_hazard_stage: vector table for hazard/forward decode plus
// hand sequences for reset, load-use, branch-over-load-use and counter saturation.
module tb_id_ex_hazard_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rs1_d, rs2_d, rd_d, rd_m, rd_w;
    logic [31:0] rd1_d, rd2_d, imm_d, pc_d;
    logic        reg_write_d, mem_read_d, mem_write_d, alu_src_d, branch_d, jump_d;
    logic [3:0]  alu_ctrl_d;
    logic        pc_src_e, reg_write_m, reg_write_w;

    logic [4:0]  rs1_e, rs2_e, rd_e;
    logic [31:0] rd1_e, rd2_e, imm_e, pc_e;
    logic        reg_write_e, mem_read_e, mem_write_e, alu_src_e, branch_e, jump_e;
    logic [3:0]  alu_ctrl_e;
    logic        stall_f, stall_d, flush_d;
    logic [1:0]  forward_a_e, forward_b_e;
    logic [15:0] stall_cnt, flush_cnt;

    logic [4:0]  s_rs1_e, s_rs2_e, s_rd_e;
    logic [31:0] s_rd1_e, s_rd2_e, s_imm_e, s_pc_e;
    logic        s_reg_write_e, s_mem_read_e, s_mem_write_e, s_alu_src_e, s_branch_e, s_jump_e;
    logic [3:0]  s_alu_ctrl_e;
    logic        s_stall_f, s_stall_d, s_flush_d;
    logic [1:0]  s_forward_a_e, s_forward_b_e;
    logic [3:0]  s_stall_cnt, s_flush_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    id_ex_hazard_stage dut (
        .clk(clk), .reset(reset),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
        .rd1_d(rd1_d), .rd2_d(rd2_d), .imm_d(imm_d), .pc_d(pc_d),
        .reg_write_d(reg_write_d), .mem_read_d(mem_read_d), .mem_write_d(mem_write_d),
        .alu_src_d(alu_src_d), .branch_d(branch_d), .jump_d(jump_d),
        .alu_ctrl_d(alu_ctrl_d), .pc_src_e(pc_src_e),
        .rd_m(rd_m), .rd_w(rd_w), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
        .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
        .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_e(imm_e), .pc_e(pc_e),
        .reg_write_e(reg_write_e), .mem_read_e(mem_read_e), .mem_write_e(mem_write_e),
        .alu_src_e(alu_src_e), .branch_e(branch_e), .jump_e(jump_e),
        .alu_ctrl_e(alu_ctrl_e),
        .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
        .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    id_ex_hazard_stage #(.CNT_W(4)) dut_small (
        .clk(clk), .reset(reset),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
        .rd1_d(rd1_d), .rd2_d(rd2_d), .imm_d(imm_d), .pc_d(pc_d),
        .reg_write_d(reg_write_d), .mem_read_d(mem_read_d), .mem_write_d(mem_write_d),
        .alu_src_d(alu_src_d), .branch_d(branch_d), .jump_d(jump_d),
        .alu_ctrl_d(alu_ctrl_d), .pc_src_e(pc_src_e),
        .rd_m(rd_m), .rd_w(rd_w), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
        .rs1_e(s_rs1_e), .rs2_e(s_rs2_e), .rd_e(s_rd_e),
        .rd1_e(s_rd1_e), .rd2_e(s_rd2_e), .imm_e(s_imm_e), .pc_e(s_pc_e),
        .reg_write_e(s_reg_write_e), .mem_read_e(s_mem_read_e), .mem_write_e(s_mem_write_e),
        .alu_src_e(s_alu_src_e), .branch_e(s_branch_e), .jump_e(s_jump_e),
        .alu_ctrl_e(s_alu_ctrl_e),
        .stall_f(s_stall_f), .stall_d(s_stall_d), .flush_d(s_flush_d),
        .forward_a_e(s_forward_a_e), .forward_b_e(s_forward_b_e),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    typedef struct {
        logic [4:0] e_rs1, e_rs2, e_rd;
        logic       e_mr;
        logic [4:0] d_rs1, d_rs2;
        logic       pc_src;
        logic [4:0] m_rd;
        logic       m_we;
        logic [4:0] w_rd;
        logic       w_we;
        logic       x_stall, x_flush;
        logic [1:0] x_fa, x_fb;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rs1_d = 0; rs2_d = 0; rd_d = 0;
        rd1_d = 0; rd2_d = 0; imm_d = 0; pc_d = 0;
        reg_write_d = 0; mem_read_d = 0; mem_write_d = 0;
        alu_src_d = 0; branch_d = 0; jump_d = 0; alu_ctrl_d = 0;
        pc_src_e = 0; rd_m = 0; rd_w = 0; reg_write_m = 0; reg_write_w = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        #1;
    endtask

    initial begin
        vecs[0]  = '{5'd1, 5'd2, 5'd5, 1'b1, 5'd1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0};
        vecs[1]  = '{5'd0, 5'd0, 5'd0, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0};
        vecs[2]  = '{5'd0, 5'd0, 5'd5, 1'b0, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0};
        vecs[3]  = '{5'd0, 5'd0, 5'd5, 1'b1, 5'd5, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0};
        vecs[4]  = '{5'd3, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd3, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 2'd2, 2'd0};
        vecs[5]  = '{5'd3, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd3, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 2'd1, 2'd0};
        vecs[6]  = '{5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0};
        vecs[7]  = '{5'd4, 5'd9, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd4, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 2'd0, 2'd1};
        vecs[8]  = '{5'd6, 5'd6, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd6, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd2};
        vecs[9]  = '{5'd0, 5'd0, 5'd7, 1'b1, 5'd7, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0};
        vecs[10] = '{5'd2, 5'd8, 5'd3, 1'b1, 5'd4, 5'd6, 1'b0, 5'd2, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0};
        vecs[11] = '{5'd31, 5'd0, 5'd31, 1'b1, 5'd0, 5'd31, 1'b0, 5'd0, 1'b0, 5'd31, 1'b1, 1'b1, 1'b0, 2'd1, 2'd0};

        clear_inputs();
        reset = 1'b1;
        #12;
        check("rst_rd_e", rd_e, 0);
        check("rst_stall_cnt", stall_cnt, 0);
        check("rst_flush_cnt", flush_cnt, 0);
        check("rst_stall_d", stall_d, 0);
        reset = 1'b0;
        tick();

        // Table: load E through a normal capture, then probe the combinational outputs.
        for (int i = 0; i < 12; i++) begin
            do_reset();
            rs1_d = vecs[i].e_rs1; rs2_d = vecs[i].e_rs2; rd_d = vecs[i].e_rd;
            mem_read_d = vecs[i].e_mr;
            tick();
            rs1_d = vecs[i].d_rs1; rs2_d = vecs[i].d_rs2; rd_d = 0; mem_read_d = 0;
            pc_src_e = vecs[i].pc_src;
            rd_m = vecs[i].m_rd; reg_write_m = vecs[i].m_we;
            rd_w = vecs[i].w_rd; reg_write_w = vecs[i].w_we;
            #1;
            check($sformatf("v%0d_stall_d", i), stall_d, vecs[i].x_stall);
            check($sformatf("v%0d_stall_f", i), stall_f, vecs[i].x_stall);
            check($sformatf("v%0d_flush_d", i), flush_d, vecs[i].x_flush);
            check($sformatf("v%0d_fwd_a", i), forward_a_e, vecs[i].x_fa);
            check($sformatf("v%0d_fwd_b", i), forward_b_e, vecs[i].x_fb);
            tick();
        end

        // Reset mid-stream: build stall_cnt=3 with a self-dependent load held in D.
        do_reset();
        mem_read_d = 1; rd_d = 5; rs1_d = 5;
        for (int i = 0; i < 6; i++) tick();
        mem_read_d = 0; rd_d = 7; rs1_d = 1; reg_write_d = 1;
        tick();
        rd_m = 1; reg_write_m = 1; pc_src_e = 1;
        #1;
        check("mid_rd_e", rd_e, 7);
        check("mid_reg_write_e", reg_write_e, 1);
        check("mid_stall_cnt", stall_cnt, 3);
        check("mid_fwd_a", forward_a_e, 2);
        check("mid_flush_d", flush_d, 1);
        reset = 1'b1;
        #1;
        check("midrst_rd_e", rd_e, 0);
        check("midrst_reg_write_e", reg_write_e, 0);
        check("midrst_rs1_e", rs1_e, 0);
        check("midrst_stall_cnt", stall_cnt, 0);
        check("midrst_flush_cnt", flush_cnt, 0);
        check("midrst_fwd_a", forward_a_e, 0);
        check("midrst_flush_d", flush_d, 0);
        check("midrst_stall_d", stall_d, 0);
        reset = 1'b0;
        pc_src_e = 0;
        tick();

        // Load-use: lw x5, then add x6, x1, x5 held one cycle, load data forwarded from WB.
        do_reset();
        mem_read_d = 1; reg_write_d = 1; rd_d = 5; rs1_d = 2;
        tick();
        mem_read_d = 0; reg_write_d = 1; rd_d = 6; rs1_d = 1; rs2_d = 5;
        rd1_d = 32'h11; rd2_d = 32'h22; imm_d = 32'h40; pc_d = 32'h100; alu_ctrl_d = 4'h3;
        #1;
        check("lu_stall_f", stall_f, 1);
        check("lu_stall_d", stall_d, 1);
        check("lu_flush_d", flush_d, 0);
        tick();
        rd_m = 5; reg_write_m = 1;
        #1;
        check("lu_bubble_mem_read_e", mem_read_e, 0);
        check("lu_bubble_rd_e", rd_e, 0);
        check("lu_bubble_reg_write_e", reg_write_e, 0);
        check("lu_stall_cnt", stall_cnt, 1);
        check("lu_cleared_stall_d", stall_d, 0);
        tick();
        rd_m = 0; reg_write_m = 0; rd_w = 5; reg_write_w = 1;
        #1;
        check("lu_held_rs2_e", rs2_e, 5);
        check("lu_held_rd_e", rd_e, 6);
        check("lu_held_rd2_e", rd2_e, 32'h22);
        check("lu_held_pc_e", pc_e, 32'h100);
        check("lu_held_imm_e", imm_e, 32'h40);
        check("lu_held_alu_ctrl_e", alu_ctrl_e, 4'h3);
        check("lu_fwd_b", forward_b_e, 1);
        check("lu_fwd_a", forward_a_e, 0);
        check("lu_stall_cnt_hold", stall_cnt, 1);
        tick();

        // Taken branch while a load-use is pending: redirect wins.
        do_reset();
        mem_read_d = 1; rd_d = 5; reg_write_d = 1;
        tick();
        mem_read_d = 0; rd_d = 8; rs1_d = 5; branch_d = 1; pc_src_e = 1;
        #1;
        check("br_stall_d", stall_d, 0);
        check("br_stall_f", stall_f, 0);
        check("br_flush_d", flush_d, 1);
        tick();
        pc_src_e = 0;
        #1;
        check("br_mem_read_e", mem_read_e, 0);
        check("br_rd_e", rd_e, 0);
        check("br_branch_e", branch_e, 0);
        check("br_flush_cnt", flush_cnt, 1);
        check("br_stall_cnt", stall_cnt, 0);

        // Saturation: 20 redirects, the 4-bit counter must pin at 15.
        do_reset();
        pc_src_e = 1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            check($sformatf("sat_small_%0d", i), s_flush_cnt, (i > 15) ? 15 : i);
            check($sformatf("sat_wide_%0d", i), flush_cnt, i);
        end
        pc_src_e = 0;
        tick();
        check("sat_small_final", s_flush_cnt, 15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_hazard_stage.md
# id_ex_hazard_stage

Pipeline register between decode (D) and execute (E) of the 5-stage RISC pipeline, with the pipeline's hazard control built in. It captures the register-file read data (RD1/RD2) and decoded control for the instruction leaving decode. It detects load-use hazards and stalls fetch/decode, and inserts bubbles on load-use and on taken branches/jumps. It also produces the EX-stage forwarding selects and keeps saturating stall/flush event counters for performance debug.

## Interface
- XLEN, 32, datapath width
- RA_W, 5, register address width
- ALU_W, 4, ALU control width
- CNT_W, 16, event counter width
- clk  in  1  rising-edge clock; the register file writes on falling edge
- reset  in  1  reset, asynchronous, active-high
- rs1_d, rs2_d, rd_d  in  RA_W each  decode-stage register addresses
- rd1_d, rd2_d  in  XLEN each  register-file read data for rs1_d/rs2_d
- imm_d, pc_d  in  XLEN each  immediate, PC of decode instruction
- reg_write_d, mem_read_d, mem_write_d, alu_src_d, branch_d, jump_d  in  1 each  decoded control
- alu_ctrl_d  in  ALU_W  ALU operation
- pc_src_e  in  1  branch taken / jump resolved in E (from ALU stage)
- rd_m, rd_w  in  RA_W  destination of MEM / WB instructions
- reg_write_m, reg_write_w  in  1  MEM / WB write enables
- rs1_e, rs2_e, rd_e  out  RA_W  registered addresses
- rd1_e, rd2_e, imm_e, pc_e  out  XLEN  registered data
- reg_write_e, mem_read_e, mem_write_e, alu_src_e, branch_e, jump_e  out  1  registered control
- alu_ctrl_e  out  ALU_W  registered ALU op
- stall_f, stall_d  out  1  hold PC and IF/ID register (combinational)
- flush_d  out  1  clear IF/ID register (combinational)
- forward_a_e, forward_b_e  out  2  EX operand select: 00 register, 01 WB result, 10 MEM result
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters

## Operation
- Load-use condition: lu = mem_read_e & rd_e≠0 & (rd_e==rs1_d | rd_e==rs2_d).
- Redirect: pc_src_e.
- stall_f = stall_d = lu & ~pc_src_e.
- flush_d = pc_src_e.
- bubble_e = lu | pc_src_e.
- Redirect has priority. When lu and pc_src_e are both high, no stall occurs; D is flushed and E gets a bubble.
- E register update, priority order:
  - reset: all E outputs 0.
  - Else bubble_e: all E outputs 0, i.e. a NOP with no write, load, store, branch or jump.
  - Else: capture every *_d input into the matching *_e output.
- There is no stall of E itself; E always advances.
- Forwarding is combinational from the registered rs1_e/rs2_e. For operand A:
  - 10 if reg_write_m & rd_m≠0 & rd_m==rs1_e;
  - else 01 if reg_write_w & rd_w≠0 & rd_w==rs1_e;
  - else 00.
  - Operand B uses the same rule with rs2_e.
  - MEM beats WB when both match.
- x0 never matches for hazards or forwarding.
- WB-to-D forwarding is not done here. The register file writes on the falling edge, so the decode read in the same cycle already returns the new value.
- Counters:
  - stall_cnt increments on each rising edge where stall_d=1.
  - flush_cnt increments on each rising edge where pc_src_e=1.
  - Both saturate at 2^CNT_W−1 and never wrap.

## Timing
- E outputs are registered, so there is 1-cycle latency from D inputs.
- Hazard and forward outputs are combinational, with zero latency from their inputs.
- Load-use costs exactly 1 stall cycle. On the next edge a bubble sits in E, mem_read_e=0, lu clears, and the held instruction proceeds. Its load data then arrives via forward 01 from WB.
- Taken branch costs 2 cycles: the D instruction is flushed and the E slot is bubbled on the same edge.
- Reset asserted at any point clears the E register and both counters immediately, with no clock needed. While reset is high, stall_f, stall_d, flush_d and forward_* are forced to 0.
- First capture happens on the first rising edge after reset deasserts.

## Test plan
- Reset mid-stream: load E with rd_e=7, reg_write_e=1 and stall_cnt=3, then pulse reset between edges. All E outputs and counters read 0 immediately, and stall/forward outputs read 0.
- Load-use: `lw x5` in E (mem_read_e=1, rd_e=5) with rs2_d=5. Required: stall_f=stall_d=1 for exactly one cycle; next edge E all-zero and stall_cnt=1; following edge captures the held instruction with forward_b_e=01 once the load is in WB.
- x0 immunity: mem_read_e=1, rd_e=0, rs1_d=0 → stall_d=0. Also reg_write_m=1, rd_m=0, rs1_e=0 → forward_a_e=00.
- Forward priority: rs1_e=3, rd_m=3, rd_w=3, both write enables high → forward_a_e=10. Drop reg_write_m → 01.
- Branch with simultaneous load-use: pc_src_e=1 and lu=1 → stall_d=0, flush_d=1. Next edge: E zeroed, flush_cnt+1, stall_cnt unchanged.
- Saturation: with CNT_W=4, hold pc_src_e high for 20 cycles → flush_cnt stays at 15, no wrap.
